// File: rtl/systolic_ws_controller.sv
// Phase sequencer for a ROWS x COLS weight-stationary systolic array:
// weight load, skewed activation streaming, drain, then a one-cycle done.
module systolic_ws_controller #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int VEC_W   = 8,
  parameter int WADDR_W = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               reuse_w,
  input  logic [VEC_W-1:0]   num_vec,
  output logic               busy,
  output logic               done,
  output logic               mode,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_rd_addr,
  output logic               a_rd_en,
  output logic [VEC_W-1:0]   a_rd_addr,
  output logic [ROWS-1:0]    row_enable,
  output logic [COLS-1:0]    col_valid
);

  localparam int PIPE = ROWS + COLS;

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WSETTLE, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t             r_state;
  logic [VEC_W-1:0]   r_n;
  logic [PIPE-1:0]    r_pipe;
  logic               r_busy, r_done, r_mode, r_w_en, r_a_en;
  logic [WADDR_W-1:0] r_w_addr;
  logic [VEC_W-1:0]   r_a_addr;
  logic               w_pipe_drained;

  // Bit k of r_pipe is a_rd_en delayed k+1 cycles: rows tap the low end,
  // columns the high end. Drained means the pipe is empty after this edge.
  assign w_pipe_drained = !r_a_en && (r_pipe[PIPE-2:0] == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_pipe   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mode   <= 1'b1;
      r_w_en   <= 1'b0;
      r_a_en   <= 1'b0;
      r_w_addr <= '0;
      r_a_addr <= '0;
    end else begin
      r_pipe <= {r_pipe[PIPE-2:0], r_a_en};
      r_mode <= ~r_w_en;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_n <= num_vec;
          if (!reuse_w) begin
            r_state  <= S_WLOAD;
            r_busy   <= 1'b1;
            r_w_en   <= 1'b1;
            r_w_addr <= WADDR_W'(ROWS - 1);
          end else if (num_vec != '0) begin
            r_state  <= S_COMPUTE;
            r_busy   <= 1'b1;
            r_a_en   <= 1'b1;
            r_a_addr <= '0;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_WLOAD: begin
          if (r_w_addr == '0) begin
            r_w_en  <= 1'b0;
            r_state <= S_WSETTLE;
          end else begin
            r_w_addr <= r_w_addr - WADDR_W'(1);
          end
        end
        S_WSETTLE: begin
          if (r_n != '0) begin
            r_state  <= S_COMPUTE;
            r_a_en   <= 1'b1;
            r_a_addr <= '0;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_COMPUTE: begin
          // Compare against N-1 so N = 2^VEC_W-1 never wraps the address.
          if (r_a_addr == r_n - VEC_W'(1)) begin
            r_a_en   <= 1'b0;
            r_a_addr <= '0;
            r_state  <= S_DRAIN;
          end else begin
            r_a_addr <= r_a_addr + VEC_W'(1);
          end
        end
        S_DRAIN: if (w_pipe_drained) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign mode       = r_mode;
  assign w_rd_en    = r_w_en;
  assign w_rd_addr  = r_w_addr;
  assign a_rd_en    = r_a_en;
  assign a_rd_addr  = r_a_addr;
  assign row_enable = r_pipe[ROWS-1:0];
  assign col_valid  = r_pipe[PIPE-1:ROWS];

endmodule
